// File: rtl/qc_ldpc_enc.sv
// rtl/qc_ldpc_enc.sv - systematic quasi-cyclic LDPC encoder, info blocks in, info+parity blocks out
// Parity block j is the XOR over info blocks i of u_i rotated by G_SHIFT(i,j).
module qc_ldpc_enc #(
    parameter int D = 8,
    parameter int R = 5,
    parameter int C = 3,
    parameter logic [(R-C)*C*$clog2(D)-1:0] G_SHIFT = 18'o753421
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [D-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [D-1:0] out_data,
    output logic         out_last
);

    localparam int KB   = R - C;
    localparam int SH_W = $clog2(D);
    localparam int CW   = $clog2(R + 1);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   in_cnt;
    logic [CW-1:0]   out_cnt;
    logic [D-1:0]    info_buf [KB];
    logic [D-1:0]    par      [C];
    logic [D-1:0]    par_nxt  [C];
    logic [SH_W-1:0] shift_sel [C];
    logic            accept;
    logic            xfer;
    logic            last_in;

    // rot(x,s)[k] = x[(k+s) mod D]: shifting the doubled word right wraps the low bits around
    function automatic logic [D-1:0] rot(input logic [D-1:0] x, input logic [SH_W-1:0] s);
        logic [2*D-1:0] w;
        w = {x, x} >> s;
        return w[D-1:0];
    endfunction

    assign accept  = in_valid & in_ready;
    assign xfer    = out_valid & out_ready;
    assign last_in = (in_cnt == CW'(KB - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: if (accept && last_in) state_nxt = S_SEND;
            S_SEND: if (xfer && out_last)  state_nxt = S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_LOAD);
        out_valid = (state == S_SEND);
        out_last  = (state == S_SEND) && (out_cnt == CW'(R - 1));
        out_data  = '0;
        if (state == S_SEND) begin
            for (int b = 0; b < R; b++) begin
                if (out_cnt == CW'(b)) begin
                    if (b < KB) out_data = info_buf[b];
                    else        out_data = par[b - KB];
                end
            end
        end
    end

    // Shift for the block being accepted is picked by in_cnt from the packed table
    always_comb begin
        for (int j = 0; j < C; j++) begin
            shift_sel[j] = '0;
            for (int i = 0; i < KB; i++) begin
                if (in_cnt == CW'(i)) shift_sel[j] = G_SHIFT[SH_W*(i*C+j) +: SH_W];
            end
            par_nxt[j] = par[j] ^ rot(in_data, shift_sel[j]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            for (int i = 0; i < KB; i++) info_buf[i] <= '0;
            for (int j = 0; j < C; j++)  par[j]      <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < KB; i++) begin
                    if (in_cnt == CW'(i)) info_buf[i] <= in_data;
                end
                for (int j = 0; j < C; j++) par[j] <= par_nxt[j];
                if (last_in) begin
                    in_cnt  <= '0;
                    out_cnt <= '0;
                end else begin
                    in_cnt <= in_cnt + CW'(1);
                end
            end
            if (xfer) begin
                if (out_last) begin
                    out_cnt <= '0;
                    for (int j = 0; j < C; j++) par[j] <= '0;
                end else begin
                    out_cnt <= out_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_qc_ldpc_enc.sv
// tb/tb_qc_ldpc_enc.sv - scoreboard bench for qc_ldpc_enc at default geometry
module tb_qc_ldpc_enc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    qc_ldpc_enc dut (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] rot_model(input logic [7:0] x, input int s);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = x[(k + s) % 8];
        return r;
    endfunction

    // G_SHIFT 18'o753421 decoded by hand: row i holds shifts for parity blocks 0..2
    task automatic push_cw(input logic [7:0] u0, input logic [7:0] u1);
        int sh [2][3];
        logic [7:0] p;
        sh = '{'{1, 2, 4}, '{3, 5, 7}};
        exp_q.push_back({1'b0, u0});
        exp_q.push_back({1'b0, u1});
        for (int j = 0; j < 3; j++) begin
            p = rot_model(u0, sh[0][j]) ^ rot_model(u1, sh[1][j]);
            exp_q.push_back({(j == 2), p});
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (out_valid) check("in_ready_in_send", in_ready, 1'b0);
            if (prev_stall && out_valid) begin
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_block", out_data, 8'hxx);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[7:0]);
                    check("out_last", out_last, e[8]);
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
            prev_last  <= out_last;
        end
    end

    // Presents u0,u1; in_data is only set to the real block once in_ready is seen, junk otherwise
    task automatic send_info(input logic [7:0] u0, input logic [7:0] u1, input bit junk_after);
        logic [7:0] u [2];
        int t;
        u = '{u0, u1};
        push_cw(u0, u1);
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            t = 0;
            forever begin
                @(negedge clk);
                if (in_ready || t > 50) break;
                t++;
            end
            if (t > 50) check("in_ready_timeout", 0, 1);
            in_data = u[i];
            @(posedge clk);
            #1;
        end
        if (junk_after) in_data = 8'hA5;
        else            in_valid = 1'b0;
    endtask

    task automatic drain;
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bit pat [8];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Case 1 with latency and in_ready-low window
        send_info(8'h01, 8'h00, 1'b0);
        check("latency_out_valid", out_valid, 1'b1);
        check("latency_in_ready", in_ready, 1'b0);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready || n > 20) break;
            n++;
        end
        check("in_ready_low_cycles", n, 5);
        drain();

        send_info(8'h00, 8'h01, 1'b0);
        drain();
        send_info(8'hFF, 8'hFF, 1'b0);
        drain();

        // Back-to-back with in_valid held high through SEND carrying junk
        send_info(8'h01, 8'h00, 1'b1);
        send_info(8'h00, 8'h01, 1'b0);
        drain();

        // Backpressure pattern
        out_ready = 1'b0;
        send_info(8'h01, 8'h00, 1'b0);
        pat = '{1, 0, 0, 1, 0, 1, 1, 1};
        for (int p = 0; p < 8; p++) begin
            out_ready = pat[p];
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // Reset mid-SEND after two blocks
        send_info(8'h01, 8'h00, 1'b0);
        n = 0;
        while (exp_q.size() != 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("two_blocks_out", exp_q.size(), 3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_data", out_data, 8'h00);
        check("mid_rst_out_last", out_last, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_info(8'h00, 8'h01, 1'b0);
        drain();
        repeat (5) @(posedge clk);
        #1;
        check("no_leftover", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
